// File: rtl/act_pkg.sv
// Shared definitions for the piecewise-linear activation pipeline.
// Mode encodings, fraction-width derivation and the power-up identity table.
package act_pkg;

    typedef enum logic [1:0] {
        MODE_INTERP = 2'd0,
        MODE_STEP   = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    function automatic int act_frac_w(input int data_w, input int addr_w);
        return data_w - addr_w;
    endfunction

    // Identity ramp; the extra top endpoint saturates at the largest positive value.
    function automatic int act_ramp_entry(input int k, input int data_w, input int addr_w);
        if (k >= (1 << addr_w)) begin
            return (1 << (data_w - 1)) - 1;
        end
        return (k - (1 << (addr_w - 1))) << (data_w - addr_w);
    endfunction

endpackage

// File: rtl/activation_lut_interp_pipe_if.sv
// Sample stream, result stream and table-write port of the activation pipeline.
// master drives samples/writes/out_ready; slave is the pipeline itself.
interface activation_lut_interp_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_z;
    logic [1:0]        in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [TAG_W-1:0]  out_tag;
    logic              lut_we;
    logic [ADDR_W:0]   lut_waddr;
    logic [DATA_W-1:0] lut_wdata;

    modport master (
        output in_valid, in_z, in_mode, in_tag, out_ready, lut_we, lut_waddr, lut_wdata,
        input  in_ready, out_valid, out_a, out_tag
    );

    modport slave (
        input  in_valid, in_z, in_mode, in_tag, out_ready, lut_we, lut_waddr, lut_wdata,
        output in_ready, out_valid, out_a, out_tag
    );
endinterface

// File: rtl/act_interp_core.sv
// Combinational segment interpolator: a = base + floor((next-base)*frac / 2^FRAC_W).
// Zero latency, no flow control; step returns base, bypass returns z.
module act_interp_core
    import act_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] next,
    input  logic        [FRAC_W-1:0] frac,
    input  logic        [1:0]        mode,
    input  logic signed [DATA_W-1:0] z,
    output logic signed [DATA_W-1:0] a
);
    localparam int PW = DATA_W + FRAC_W + 2;

    logic signed [DATA_W:0]   diff;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     step;
    logic signed [DATA_W-1:0] interp;

    always_comb begin
        diff   = (DATA_W+1)'(next) - (DATA_W+1)'(base);
        prod   = PW'(diff) * PW'($signed({1'b0, frac}));
        step   = prod >>> FRAC_W;
        // Result lies between base and next, so plain truncation is exact.
        interp = DATA_W'(PW'(base) + step);
        case (mode)
            MODE_STEP:   a = base;
            MODE_BYPASS: a = z;
            default:     a = interp;
        endcase
    end
endmodule

// File: rtl/activation_lut_interp_pipe.sv
// Runtime-programmable piecewise-linear activation, 3-cycle latency, 1 sample/cycle.
// Single global stall: every stage holds while out_valid && !out_ready; in_ready mirrors it.
module activation_lut_interp_pipe
    import act_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int TAG_W  = 4
) (
    input logic clk,
    input logic rst,
    activation_lut_interp_pipe_if.slave io
);
    localparam int FRAC_W = act_frac_w(DATA_W, ADDR_W);
    localparam int NENT   = (1 << ADDR_W) + 1;
    localparam logic [ADDR_W:0]   TOP_IDX = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] SEG_MSB = ADDR_W'(1) << (ADDR_W - 1);

    logic signed [DATA_W-1:0] tbl_q [NENT];
    logic signed [DATA_W-1:0] tbl_d [NENT];

    logic              en;
    logic [ADDR_W-1:0] seg, idx_in;
    logic [ADDR_W:0]   idx_lo, idx_hi;

    logic                     s1_vld_q, s1_vld_d;
    logic signed [DATA_W-1:0] s1_z_q, s1_z_d, s1_base_q, s1_base_d, s1_next_q, s1_next_d;
    logic [1:0]               s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0]         s1_tag_q, s1_tag_d;

    logic                     s2_vld_q, s2_vld_d;
    logic signed [DATA_W-1:0] s2_z_q, s2_z_d, s2_base_q, s2_base_d, s2_next_q, s2_next_d;
    logic [FRAC_W-1:0]        s2_frac_q, s2_frac_d;
    logic [1:0]               s2_mode_q, s2_mode_d;
    logic [TAG_W-1:0]         s2_tag_q, s2_tag_d;

    logic                     out_vld_q, out_vld_d;
    logic signed [DATA_W-1:0] out_a_q, out_a_d, core_a;
    logic [TAG_W-1:0]         out_tag_q, out_tag_d;

    act_interp_core #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .base (s2_base_q),
        .next (s2_next_q),
        .frac (s2_frac_q),
        .mode (s2_mode_q),
        .z    (s2_z_q),
        .a    (core_a)
    );

    always_comb begin
        en     = !out_vld_q || io.out_ready;
        seg    = io.in_z[DATA_W-1:FRAC_W];
        idx_in = seg ^ SEG_MSB;
        idx_lo = {1'b0, idx_in};
        idx_hi = idx_lo + (ADDR_W+1)'(1);

        tbl_d = tbl_q;
        if (io.lut_we && io.lut_waddr <= TOP_IDX) begin
            tbl_d[io.lut_waddr] = io.lut_wdata;
        end

        s1_vld_d  = s1_vld_q;  s1_z_d    = s1_z_q;    s1_mode_d = s1_mode_q;
        s1_tag_d  = s1_tag_q;  s1_base_d = s1_base_q; s1_next_d = s1_next_q;
        s2_vld_d  = s2_vld_q;  s2_z_d    = s2_z_q;    s2_mode_d = s2_mode_q;
        s2_tag_d  = s2_tag_q;  s2_base_d = s2_base_q; s2_next_d = s2_next_q;
        s2_frac_d = s2_frac_q;
        out_vld_d = out_vld_q; out_a_d   = out_a_q;   out_tag_d = out_tag_q;

        if (en) begin
            s1_vld_d = io.in_valid;
            // Table is read in the accept cycle, so a same-cycle write is not yet visible.
            if (io.in_valid) begin
                s1_z_d    = io.in_z;
                s1_mode_d = io.in_mode;
                s1_tag_d  = io.in_tag;
                s1_base_d = tbl_q[idx_lo];
                s1_next_d = tbl_q[idx_hi];
            end
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_z_d    = s1_z_q;
                s2_mode_d = s1_mode_q;
                s2_tag_d  = s1_tag_q;
                s2_base_d = s1_base_q;
                s2_next_d = s1_next_q;
                s2_frac_d = s1_z_q[FRAC_W-1:0];
            end
            out_vld_d = s2_vld_q;
            if (s2_vld_q) begin
                out_a_d   = core_a;
                out_tag_d = s2_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NENT; k++) begin
                tbl_q[k] <= DATA_W'(act_ramp_entry(k, DATA_W, ADDR_W));
            end
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_a_q   <= '0;
            out_tag_q <= '0;
        end else begin
            tbl_q     <= tbl_d;
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            out_vld_q <= out_vld_d;
            out_a_q   <= out_a_d;
            out_tag_q <= out_tag_d;
        end
    end

    // Data stages carry no reset; their contents only matter under a set valid.
    always_ff @(posedge clk) begin
        s1_z_q    <= s1_z_d;    s1_mode_q <= s1_mode_d; s1_tag_q  <= s1_tag_d;
        s1_base_q <= s1_base_d; s1_next_q <= s1_next_d;
        s2_z_q    <= s2_z_d;    s2_mode_q <= s2_mode_d; s2_tag_q  <= s2_tag_d;
        s2_base_q <= s2_base_d; s2_next_q <= s2_next_d; s2_frac_q <= s2_frac_d;
    end

    assign io.in_ready  = en;
    assign io.out_valid = out_vld_q;
    assign io.out_a     = out_a_q;
    assign io.out_tag   = out_tag_q;
endmodule

// File: tb/tb_activation_lut_interp_pipe.sv
// Scoreboard bench: the driver queues the expected result of every accepted sample,
// a negedge monitor pops and compares whenever the pipeline hands a result downstream.
module tb_activation_lut_interp_pipe;
    import act_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    activation_lut_interp_pipe_if #(.DATA_W(8), .ADDR_W(4), .TAG_W(4)) bus ();

    activation_lut_interp_pipe #(.DATA_W(8), .ADDR_W(4), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [3:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sweep_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent integer model of the default identity-ramp table.
    function automatic int ramp(input int k);
        return (k == 16) ? 127 : (k - 8) * 16;
    endfunction

    function automatic logic [7:0] ref_a(input logic [7:0] z, input logic [1:0] m);
        int idx, base, nxt, fr;
        idx  = int'(z[7:4]) ^ 8;
        base = ramp(idx);
        nxt  = ramp(idx + 1);
        fr   = int'(z[3:0]);
        case (m)
            2'd1:    return 8'(base);
            2'd2:    return z;
            default: return 8'(base + (((nxt - base) * fr) >>> 4));
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got a=0x%0h tag=%0d, expected no output", bus.out_a, bus.out_tag);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_a", bus.out_a, mon_e.a);
                chk("out_tag", bus.out_tag, mon_e.tag);
            end
        end
    end

    task automatic send(input logic [7:0] z, input logic [1:0] m, input logic [3:0] t, input logic [7:0] e);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_z     = z;
        bus.in_mode  = m;
        bus.in_tag   = t;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready 0 for 200 cycles, expected 1 (z=0x%0h)", z);
        end else begin
            exp_q.push_back('{a: e, tag: t});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [7:0] data);
        bus.lut_we    = 1'b1;
        bus.lut_waddr = addr;
        bus.lut_wdata = data;
        @(negedge clk);
        bus.lut_we    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic chk_reset_state(input string tagname);
        chk({tagname, "_out_valid"}, bus.out_valid, 0);
        chk({tagname, "_in_ready"}, bus.in_ready, 1);
        chk({tagname, "_out_a"}, bus.out_a, 0);
        chk({tagname, "_out_tag"}, bus.out_tag, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_z      = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        bus.lut_we    = 1'b0;
        bus.lut_waddr = '0;
        bus.lut_wdata = '0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset");

        // Identity ramp, interpolate mode.
        send(8'h25, 2'd0, 4'd1, 8'h25);
        send(8'h80, 2'd0, 4'd2, 8'h80);
        send(8'h7F, 2'd0, 4'd3, 8'h7E);
        drain();

        // Accept-to-valid latency on an empty pipeline.
        send(8'h10, 2'd0, 4'd4, 8'h10);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency_negedges_after_accept", n, 2);
        drain();

        // Programmed segment: base 100, next -100.
        wr(5'd10, 8'h64);
        wr(5'd11, 8'h9C);
        send(8'h28, 2'd0, 4'd5, 8'h00);
        send(8'h28, 2'd1, 4'd6, 8'h64);
        send(8'h28, 2'd2, 4'd7, 8'h28);
        send(8'h28, 2'd3, 4'd8, 8'h00);
        drain();

        // Restore ramp entries, then write T[10] in the same cycle a sample is accepted.
        wr(5'd10, 8'h20);
        wr(5'd11, 8'h30);
        bus.lut_we    = 1'b1;
        bus.lut_waddr = 5'd10;
        bus.lut_wdata = 8'h40;
        send(8'h20, 2'd0, 4'd9, 8'h20);
        bus.lut_we    = 1'b0;
        send(8'h20, 2'd0, 4'd10, 8'h40);
        drain();

        // Backpressure: downstream stalls while samples 1..6 stream in.
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    send(8'(i), 2'd0, 4'(i), 8'(i));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #2 bus.out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("stall_in_ready", bus.in_ready, 0);
                    chk("stall_out_valid", bus.out_valid, 1);
                    chk("stall_out_a_hold", bus.out_a, 8'h01);
                    chk("stall_out_tag_hold", bus.out_tag, 4'd1);
                end
                @(posedge clk);
                #2 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three samples in flight.
        bus.out_ready = 1'b0;
        send(8'h30, 2'd0, 4'd1, 8'h30);
        send(8'h31, 2'd0, 4'd2, 8'h31);
        send(8'h32, 2'd0, 4'd3, 8'h32);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk_reset_state("midreset");
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("midreset_out_valid_count", n, 0);

        // Table back to the ramp after reset.
        send(8'h28, 2'd0, 4'd4, 8'h28);
        send(8'h20, 2'd0, 4'd5, 8'h20);
        drain();

        // Out-of-range write must not land anywhere.
        wr(5'd17, 8'h55);
        send(8'h98, 2'd0, 4'd6, 8'h98);
        send(8'h7F, 2'd0, 4'd7, 8'h7E);
        send(8'h88, 2'd0, 4'd8, 8'h88);
        drain();

        // All 256 inputs in each mode, with random downstream stalls.
        sweep_on = 1'b1;
        fork
            begin
                while (sweep_on) begin
                    @(posedge clk);
                    #2 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
            begin
                for (int m = 0; m < 4; m++) begin
                    for (int i = 0; i < 256; i++) begin
                        logic [7:0] z;
                        z = 8'(i * 167 + 13);
                        send(z, 2'(m), 4'(i), ref_a(z, 2'(m)));
                    end
                end
                sweep_on = 1'b0;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
